seg_scan_display: RTL and testbench

- Parametrised, time-multiplexed 7-segment driver; successor to the fixed 4-digit display block.
- Scans NUM_DIGITS common-anode digits from one system clock using an internal refresh prescaler.
- Adds per-digit decimal points, a sign digit, leading-zero blanking, hex/BCD mode, display enable and tear-free frame snapshotting.
- Sits between the datapath result registers and the board's segment/anode pins.

---
 rtl/seg_pkg.sv | 12 +
 rtl/seg_decoder.sv | 10 +
 rtl/seg_scan_display.sv | 82 ++++++++
 tb/tb_seg_scan_display.sv | 99 +++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared segment types and active-low glyph patterns in a..g ([0:6]) order.
package seg_pkg;
  typedef logic [0:6] seg_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_MINUS = 7'b1111110;
  localparam seg_t SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: nibble to active-low segments; 10..15 blank unless hex mode.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [0:6] seg_o
);
  always_comb seg_o = (nibble_i > 4'd9 && !hex_mode_i) ? SEG_BLANK : SEG_LUT[nibble_i];
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed 7-segment scanner with per-frame snapshot,
// sign digit, leading-zero blanking and registered active-low outputs.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 25000,
  parameter bit SIGN_EN    = 1,
  parameter bit HEX_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    sign_in,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [0:6]              segments,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   anode_active,
  output logic                    frame_done
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] ONE = 1;
  logic [PW-1:0]             presc_q;
  logic [IW-1:0]             idx_q;
  logic [4*NUM_DIGITS-1:0]   dig_q;
  logic [NUM_DIGITS-1:0]     dp_q;
  logic                      sign_q, blz_q;
  logic                      tick, wrap, sign_pos, run;
  logic [NUM_DIGITS-1:0]     lz;
  logic [0:6]                dec_seg, seg_d;
  assign tick     = presc_q == PW'(CLK_DIV - 1);
  assign wrap     = tick && idx_q == IW'(NUM_DIGITS - 1);
  assign sign_pos = SIGN_EN && idx_q == IW'(NUM_DIGITS - 1);
  // lz[k]: digit k and every value digit above it are zero (sign slot excluded)
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      if (!(SIGN_EN && k == NUM_DIGITS - 1)) begin
        run   = run && dig_q[4*k +: 4] == 4'd0;
        lz[k] = run;
      end
    end
  end
  seg_decoder u_dec (
    .nibble_i   (dig_q[{idx_q, 2'b00} +: 4]),
    .hex_mode_i (HEX_MODE),
    .seg_o      (dec_seg)
  );
  always_comb seg_d = sign_pos ? (sign_q ? SEG_MINUS : SEG_BLANK)
                    : (blz_q && lz[idx_q]) ? SEG_BLANK : dec_seg;
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      dig_q        <= '0;
      dp_q         <= '0;
      sign_q       <= 1'b0;
      blz_q        <= 1'b0;
      segments     <= SEG_BLANK;
      dp_out       <= 1'b1;
      anode_active <= '1;
      frame_done   <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      idx_q   <= wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
      if (wrap) begin
        dig_q  <= digits_in;
        dp_q   <= dp_in;
        sign_q <= sign_in;
        blz_q  <= blank_lz;
      end
      frame_done   <= wrap;
      anode_active <= enable ? ~(ONE << idx_q) : '1;
      segments     <= enable ? seg_d : SEG_BLANK;
      dp_out       <= enable ? ~dp_q[idx_q] : 1'b1;
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed checks of scan timing, snapshot, blanking, sign, hex and reset.
module tb_seg_scan_display;
  localparam logic [6:0] S0 = 7'b0000001, S2 = 7'b0010010, S3 = 7'b0000110, S4 = 7'b1001100;
  localparam logic [6:0] S7 = 7'b0001111, S8 = 7'b0000000, S9 = 7'b0000100, SB = 7'b1100000;
  localparam logic [6:0] BL = 7'h7F, MI = 7'b1111110;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] digits_in = 16'h1234;
  logic [3:0] dp_in = 4'b0000;
  logic sign_in = 1'b0, blank_lz = 1'b0, enable = 1'b1;
  logic [0:6] seg0, seg1;
  logic dp0, dp1, fd0, fd1;
  logic [3:0] an0, an1;
  int errors = 0, checks = 0, cyc = 0;
  seg_scan_display #(.NUM_DIGITS(4), .CLK_DIV(4), .SIGN_EN(1), .HEX_MODE(0)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .sign_in(sign_in),
    .blank_lz(blank_lz), .enable(enable), .segments(seg0), .dp_out(dp0),
    .anode_active(an0), .frame_done(fd0));
  seg_scan_display #(.NUM_DIGITS(4), .CLK_DIV(4), .SIGN_EN(1), .HEX_MODE(1)) dut_hex (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .sign_in(sign_in),
    .blank_lz(blank_lz), .enable(enable), .segments(seg1), .dp_out(dp1),
    .anode_active(an1), .frame_done(fd1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic adv(input int t);
    while (cyc < t) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask
  task automatic slot(input string tag, input logic [3:0] an, input logic [6:0] sg, input logic dp);
    chk({tag, ".an"}, 32'(an0), 32'(an));
    chk({tag, ".seg"}, 32'(seg0), 32'(sg));
    chk({tag, ".dp"}, 32'(dp0), 32'(dp));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    slot("rst", 4'b1111, BL, 1'b1);
    chk("rst.fd", 32'(fd0), 0);
    rst = 1'b1;
    adv(1);  slot("f0.d0", 4'b1110, S0, 1'b1);
    adv(4);  slot("f0.d0end", 4'b1110, S0, 1'b1);
    adv(5);  slot("f0.d1", 4'b1101, S0, 1'b1);
    adv(13); slot("f0.d3", 4'b0111, BL, 1'b1);
    adv(15); chk("fd15", 32'(fd0), 0);
    adv(16); chk("fd16", 32'(fd0), 1);
    chk("fd16.an", 32'(an0), 32'(4'b0111));
    adv(17); slot("f1.d0", 4'b1110, S4, 1'b1);
    chk("fd17", 32'(fd0), 0);
    adv(21); slot("f1.d1", 4'b1101, S3, 1'b1);
    adv(25); slot("f1.d2", 4'b1011, S2, 1'b1);
    adv(29); slot("f1.d3", 4'b0111, BL, 1'b1);
    adv(30);
    digits_in = 16'h0007; sign_in = 1'b1; blank_lz = 1'b1; dp_in = 4'b0100;
    adv(31); slot("f1.hold", 4'b0111, BL, 1'b1);
    adv(33); slot("f2.d0", 4'b1110, S7, 1'b1);
    adv(37); slot("f2.d1", 4'b1101, BL, 1'b1);
    adv(38); digits_in = 16'h0987;
    adv(41); slot("f2.d2", 4'b1011, BL, 1'b0);
    adv(45); slot("f2.d3", 4'b0111, MI, 1'b1);
    adv(49); slot("f3.d0", 4'b1110, S7, 1'b1);
    adv(53); slot("f3.d1", 4'b1101, S8, 1'b1);
    adv(57); slot("f3.d2", 4'b1011, S9, 1'b0);
    adv(58); digits_in = 16'h0000; dp_in = 4'b0000;
    adv(61); slot("f3.d3", 4'b0111, MI, 1'b1);
    adv(65); slot("f4.d0", 4'b1110, S0, 1'b1);
    adv(69); slot("f4.d1", 4'b1101, BL, 1'b1);
    adv(73); slot("f4.d2", 4'b1011, BL, 1'b1);
    adv(77); slot("f4.d3", 4'b0111, MI, 1'b1);
    adv(78); digits_in = 16'h00B0; blank_lz = 1'b0; sign_in = 1'b0;
    adv(81); slot("f5.d0", 4'b1110, S0, 1'b1);
    adv(85); slot("f5.d1.hex0", 4'b1101, BL, 1'b1);
    chk("f5.d1.hex1.seg", 32'(seg1), 32'(SB));
    chk("f5.d1.hex1.an", 32'(an1), 32'(4'b1101));
    adv(86); enable = 1'b0;
    adv(87); slot("dis", 4'b1111, BL, 1'b1);
    adv(88); rst = 1'b0;
    adv(89); slot("rst2", 4'b1111, BL, 1'b1);
    chk("rst2.fd", 32'(fd0), 0);
    adv(91); slot("rst2.hold", 4'b1111, BL, 1'b1);
    rst = 1'b1; enable = 1'b1; cyc = 0;
    adv(1);  slot("r.d0", 4'b1110, S0, 1'b1);
    adv(4);  slot("r.d0end", 4'b1110, S0, 1'b1);
    adv(5);  slot("r.d1", 4'b1101, S0, 1'b1);
    adv(16); chk("r.fd16", 32'(fd0), 1);
    adv(21); chk("r.hex1.seg", 32'(seg1), 32'(SB));
    chk("r.hex0.seg", 32'(seg0), 32'(BL));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
